// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller slave port between the real-time frame reader
// and the bulk frame writer, with streak-based fairness and a cap on outstanding reads.
module sdram_port_arbiter #(
  parameter int ADDR_W        = 25,
  parameter int DATA_W        = 16,
  parameter int MAX_PENDING   = 8,
  parameter int RD_STREAK_MAX = 32,
  parameter int WR_STREAK_MAX = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iLOAD_MODE,
  input  logic              iRD_EN,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic              oRD_WAIT_REQUEST,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oRD_DATAVALID,
  input  logic              iWR_EN,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  output logic              oWR_WAIT_REQUEST,
  output logic [ADDR_W-1:0] oSDRAM_ADDR,
  output logic [DATA_W-1:0] oSDRAM_WRITEDATA,
  output logic              oSDRAM_READ_N,
  output logic              oSDRAM_WRITE_N,
  input  logic              iSDRAM_WAIT_REQUEST,
  input  logic [DATA_W-1:0] iSDRAM_READDATA,
  input  logic              iSDRAM_READDATAVALID,
  output logic [3:0]        oPENDING
);
  localparam int RSW = $clog2(RD_STREAK_MAX + 1);
  localparam int WSW = $clog2(WR_STREAK_MAX + 1);
  typedef enum logic [1:0] {NONE, RD, WR} owner_t;
  owner_t owner, owner_n;
  logic [3:0] pending, pending_n;
  logic [RSW-1:0] rd_streak, rd_streak_n;
  logic [WSW-1:0] wr_streak, wr_streak_n;
  logic rd_ok, rd_strobe, wr_strobe, rd_acc, wr_acc, rd_elig, rearb;
  always_comb begin
    rd_ok = pending != 4'(MAX_PENDING);
    rd_strobe = (owner == RD) & iRD_EN & rd_ok;
    wr_strobe = (owner == WR) & iWR_EN;
    rd_acc = rd_strobe & ~iSDRAM_WAIT_REQUEST;
    wr_acc = wr_strobe & ~iSDRAM_WAIT_REQUEST;
    rd_elig = iRD_EN & rd_ok;
    rearb = (owner == NONE) | rd_acc | wr_acc | ((owner == RD) & ~iRD_EN) | ((owner == WR) & ~iWR_EN);
    rd_streak_n = (wr_acc | ~iWR_EN) ? '0 :
                  (rd_acc & (rd_streak != RSW'(RD_STREAK_MAX))) ? rd_streak + 1'b1 : rd_streak;
    wr_streak_n = (rd_acc | ~iRD_EN) ? '0 :
                  (wr_acc & (wr_streak != WSW'(WR_STREAK_MAX))) ? wr_streak + 1'b1 : wr_streak;
    pending_n = (rd_acc & ~iSDRAM_READDATAVALID) ? pending + 4'd1 :
                (~rd_acc & iSDRAM_READDATAVALID & (pending != '0)) ? pending - 4'd1 : pending;
    owner_n = owner;
    // fairness decisions use the streaks as updated by this cycle's accept
    if (rearb)
      owner_n = iLOAD_MODE ? (iWR_EN ? WR : NONE) :
                (rd_elig & iWR_EN) ? (((owner == WR) && (wr_streak_n < WSW'(WR_STREAK_MAX))) ? WR :
                                      (rd_streak_n == RSW'(RD_STREAK_MAX)) ? WR : RD) :
                rd_elig ? RD : iWR_EN ? WR : NONE;
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      owner     <= NONE;
      pending   <= '0;
      rd_streak <= '0;
      wr_streak <= '0;
    end else begin
      owner     <= owner_n;
      pending   <= pending_n;
      rd_streak <= rd_streak_n;
      wr_streak <= wr_streak_n;
    end
  end
  assign oSDRAM_ADDR      = (owner == RD) ? iRD_ADDR : (owner == WR) ? iWR_ADDR : '0;
  assign oSDRAM_WRITEDATA = iWR_DATA;
  assign oSDRAM_READ_N    = ~rd_strobe;
  assign oSDRAM_WRITE_N   = ~wr_strobe;
  assign oRD_WAIT_REQUEST = (owner != RD) | ~rd_ok | iSDRAM_WAIT_REQUEST;
  assign oWR_WAIT_REQUEST = (owner != WR) | iSDRAM_WAIT_REQUEST;
  assign oRD_DATA         = iSDRAM_READDATA;
  assign oRD_DATAVALID    = iSDRAM_READDATAVALID & ~iRST;
  assign oPENDING         = pending;
endmodule
